cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter FBUF_DEPTH, default 307200, frame buffer depth in 16-bit pixels.
REQ-002 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port i_p_clk  input  1  camera pixel clock; sole clock.
REQ-005 SHALL have port i_rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_enable  input  1  capture enable, level.
REQ-007 SHALL have port i_vsync  input  1  camera VSYNC, high = vertical blanking.
REQ-008 SHALL have port i_href  input  1  camera HREF, high = valid byte on i_data.
REQ-009 SHALL have port i_data  input  8  camera byte, RGB565 high byte first.
REQ-010 SHALL have port o_wr  output  1  frame buffer write strobe, one cycle per pixel.
REQ-011 SHALL have port o_waddr  output  19  frame buffer write address.
REQ-012 SHALL have port o_wdata  output  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
REQ-013 SHALL have port o_frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-014 SHALL have port o_frame_count  output  8  captured-frame counter.
REQ-015 SHALL have port o_line_err  output  1  sticky line-length error; present only with CAPTURE_LINE_CHECK_EN.

Function
REQ-016 SHALL register i_vsync, i_href, i_data once (stage S1) before any use.
REQ-017 SHALL detect VSYNC edges by comparing S1 vsync to its value one cycle earlier.
REQ-018 SHALL use FSM states IDLE, SYNC, CAPTURE.
REQ-019 SHALL move IDLE->SYNC when i_enable=1; i_enable=0 in IDLE holds IDLE.
REQ-020 SHALL move SYNC->CAPTURE on S1 vsync falling edge, clearing address to 0 and byte phase to 0.
REQ-021 SHALL move CAPTURE->SYNC on S1 vsync rising edge if i_enable=1, else CAPTURE->IDLE.
REQ-022 SHALL pulse o_frame_done for exactly one cycle on every CAPTURE exit and increment o_frame_count by 1, wrapping 255->0.
REQ-023 SHALL ignore i_enable deassertion in CAPTURE until the frame ends (no partial-frame abort).
REQ-024 SHALL, in CAPTURE with S1 href=1, latch phase-0 byte as high byte, toggle phase, and on phase-1 byte form the pixel {high,low}.
REQ-025 SHALL assert o_wr with o_wdata and o_waddr valid one cycle after the phase-1 byte is in S1 (two i_p_clk edges after it is on i_data).
REQ-026 SHALL increment o_waddr by 1 after each write; after FBUF_DEPTH-1 it SHALL wrap to 0.
REQ-027 SHALL reset byte phase to 0 whenever S1 href=0; a trailing odd byte is discarded, no write.
REQ-028 SHALL not write in IDLE or SYNC regardless of href/data.
REQ-029 SHALL hold o_wdata and o_waddr at last written values when o_wr=0.
REQ-030 SHALL give a vsync rising edge priority over a same-cycle pixel completion: that pixel is dropped.

Reset
REQ-031 SHALL, on i_rst=1, asynchronously force state IDLE, S1 registers 0, byte phase 0, o_wr=0, o_waddr=0, o_wdata=0, o_frame_done=0, o_frame_count=0, o_line_err=0.
REQ-032 SHALL, after reset mid-frame, require a fresh vsync falling edge before any write.

Configuration
REQ-033 SHALL use macro CAPTURE_LINE_CHECK_EN.
REQ-034 With CAPTURE_LINE_CHECK_EN defined: count pixels per href-high run in CAPTURE; on href falling edge with count != H_ACTIVE, set o_line_err=1 until i_rst; frame capture unaffected.
REQ-035 Without CAPTURE_LINE_CHECK_EN: no o_line_err port, no line counter logic.

Verification
REQ-036 Enable, vsync 1->0, one line of 1280 bytes 0xF8,0x1F repeated -> 640 o_wr pulses, o_wdata=0xF81F, o_waddr 0..639, first o_wr 2 cycles after second byte.
REQ-037 Full 640x480 frame then vsync rise -> 307200 writes, last o_waddr=307199, one o_frame_done pulse, o_frame_count=1.
REQ-038 Line of 1281 bytes -> 640 writes, odd byte dropped, next line starts at phase 0; with CAPTURE_LINE_CHECK_EN o_line_err=1.
REQ-039 i_enable dropped mid-frame -> writes continue to frame end, o_frame_done pulses, FSM IDLE, no writes in next frame.
REQ-040 i_rst asserted mid-line -> all outputs 0 immediately; bytes before next vsync falling edge produce no o_wr.

Source files
------------

// File: rtl/cam_capture.sv
// Parallel camera capture: assembles RGB565 pixels from byte pairs and writes them to a frame buffer.
// Optional line-length checker is enabled with the CAPTURE_LINE_CHECK_EN macro.
module cam_capture #(
  parameter int unsigned FBUF_DEPTH = 307200,
  parameter int unsigned H_ACTIVE   = 640
) (
  input  logic        i_p_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic        o_wr,
  output logic [18:0] o_waddr,
  output logic [15:0] o_wdata,
  output logic        o_frame_done,
  output logic [7:0]  o_frame_count
`ifdef CAPTURE_LINE_CHECK_EN
  ,
  output logic        o_line_err
`endif
);

  localparam logic [18:0] LastAddr = 19'(FBUF_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StSync, StCapture} state_e;

  state_e      state_q, state_d;
  logic        s1_vsync, s1_href;
  logic [7:0]  s1_data;
  logic        vsync_prev;
  logic        phase_q;
  logic [7:0]  hi_q;
  logic [18:0] addr_q;
  logic        vs_fall, vs_rise;
  logic        frame_start, frame_end;
  logic        capturing;

  always_ff @(posedge i_p_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vsync   <= 1'b0;
      s1_href    <= 1'b0;
      s1_data    <= 8'd0;
      vsync_prev <= 1'b0;
      state_q    <= StIdle;
    end else begin
      s1_vsync   <= i_vsync;
      s1_href    <= i_href;
      s1_data    <= i_data;
      vsync_prev <= s1_vsync;
      state_q    <= state_d;
    end
  end

  assign vs_fall   = vsync_prev & ~s1_vsync;
  assign vs_rise   = ~vsync_prev & s1_vsync;
  assign capturing = (state_q == StCapture);

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_enable) state_d = StSync;
      end
      StSync: begin
        if (vs_fall) begin
          state_d     = StCapture;
          frame_start = 1'b1;
        end
      end
      StCapture: begin
        // Enable is only sampled at frame end so a frame is never cut short.
        if (vs_rise) begin
          frame_end = 1'b1;
          state_d   = i_enable ? StSync : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_p_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q       <= 1'b0;
      hi_q          <= 8'd0;
      addr_q        <= 19'd0;
      o_wr          <= 1'b0;
      o_waddr       <= 19'd0;
      o_wdata       <= 16'd0;
      o_frame_done  <= 1'b0;
      o_frame_count <= 8'd0;
    end else begin
      o_wr         <= 1'b0;
      o_frame_done <= frame_end;
      if (frame_end) o_frame_count <= o_frame_count + 8'd1;

      if (frame_start) begin
        addr_q  <= 19'd0;
        phase_q <= 1'b0;
      end else if (!capturing || !s1_href) begin
        phase_q <= 1'b0;
      end else if (!phase_q) begin
        hi_q    <= s1_data;
        phase_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        // A pixel completing on the vsync rising edge belongs to no frame; drop it.
        if (!vs_rise) begin
          o_wr    <= 1'b1;
          o_wdata <= {hi_q, s1_data};
          o_waddr <= addr_q;
          addr_q  <= (addr_q == LastAddr) ? 19'd0 : addr_q + 19'd1;
        end
      end
    end
  end

`ifdef CAPTURE_LINE_CHECK_EN
  logic        href_prev;
  logic [15:0] line_cnt_q;
  logic        pix_done;

  assign pix_done = capturing & s1_href & phase_q & ~vs_rise;

  always_ff @(posedge i_p_clk or posedge i_rst) begin
    if (i_rst) begin
      href_prev  <= 1'b0;
      line_cnt_q <= 16'd0;
      o_line_err <= 1'b0;
    end else begin
      href_prev <= s1_href;
      if (!capturing) begin
        line_cnt_q <= 16'd0;
      end else if (href_prev && !s1_href) begin
        // A dangling odd byte (phase still set) also marks the line as malformed.
        if (line_cnt_q != 16'(H_ACTIVE) || phase_q) o_line_err <= 1'b1;
        line_cnt_q <= 16'd0;
      end else if (pix_done && line_cnt_q != 16'hFFFF) begin
        line_cnt_q <= line_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Directed self-checking bench for cam_capture (scaled frame buffer depth, full line width).
module tb_cam_capture;

  localparam int unsigned Depth = 2560;
  localparam int unsigned HAct  = 640;

  logic        clk = 1'b0;
  logic        i_rst, i_enable, i_vsync, i_href;
  logic [7:0]  i_data;
  logic        o_wr, o_frame_done;
  logic [18:0] o_waddr;
  logic [15:0] o_wdata;
  logic [7:0]  o_frame_count;
`ifdef CAPTURE_LINE_CHECK_EN
  logic        o_line_err;
`endif

  cam_capture #(.FBUF_DEPTH(Depth), .H_ACTIVE(HAct)) dut (
    .i_p_clk      (clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_vsync      (i_vsync),
    .i_href       (i_href),
    .i_data       (i_data),
    .o_wr         (o_wr),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_frame_done (o_frame_done),
    .o_frame_count(o_frame_count)
`ifdef CAPTURE_LINE_CHECK_EN
    ,
    .o_line_err   (o_line_err)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_fc = 0;

  // Write monitor: accumulates counts only, tasks do the comparing.
  int          wr_cnt, bad_seq, bad_data, done_cnt;
  logic [18:0] first_addr, last_addr, nxt_addr;
  logic [15:0] last_data, exp_data;
  logic        chk_data;

  always @(negedge clk) begin
    if (o_frame_done) done_cnt++;
    if (o_wr) begin
      nxt_addr = (last_addr == 19'(Depth - 1)) ? 19'd0 : last_addr + 19'd1;
      if (wr_cnt == 0) first_addr = o_waddr;
      else if (o_waddr !== nxt_addr) bad_seq++;
      if (chk_data && o_wdata !== exp_data) bad_data++;
      last_addr = o_waddr;
      last_data = o_wdata;
      wr_cnt++;
    end
  end

  task automatic clear_mon(input logic chk, input logic [15:0] ed);
    wr_cnt = 0; bad_seq = 0; bad_data = 0; done_cnt = 0;
    first_addr = '0; last_addr = '0; last_data = '0;
    chk_data = chk; exp_data = ed;
  endtask

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    i_vsync = v; i_href = h; i_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, (i % 2 == 1) ? b : a);
    repeat (4) cyc(1'b0, 1'b0, 8'd0);
  endtask

  task automatic frame_start();
    repeat (3) cyc(1'b1, 1'b0, 8'd0);
    repeat (3) cyc(1'b0, 1'b0, 8'd0);
  endtask

  task automatic frame_end();
    repeat (4) cyc(1'b1, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b0; i_vsync = 1'b0; i_href = 1'b0; i_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr got %0d want 0", o_wr); end
    n_cmp++; if (o_waddr !== 19'd0) begin n_bad++; $display("FAIL reset_waddr got %0d want 0", o_waddr); end
    n_cmp++; if (o_wdata !== 16'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", o_wdata); end
    n_cmp++; if (o_frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0d want 0", o_frame_done); end
    n_cmp++; if (o_frame_count !== 8'd0) begin n_bad++; $display("FAIL reset_fc got %0d want 0", o_frame_count); end
    i_rst = 1'b0;
    i_enable = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_line();
    clear_mon(1'b1, 16'hF81F);
    frame_start();
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b0, 1'b1, 8'h1F);
    n_cmp++; if (o_wr !== 1'b0) begin n_bad++; $display("FAIL line_early_wr got %0d want 0", o_wr); end
    cyc(1'b0, 1'b1, 8'hF8);
    n_cmp++; if (o_wr !== 1'b1) begin n_bad++; $display("FAIL line_first_wr got %0d want 1", o_wr); end
    n_cmp++; if (o_waddr !== 19'd0) begin n_bad++; $display("FAIL line_first_addr got %0d want 0", o_waddr); end
    n_cmp++; if (o_wdata !== 16'hF81F) begin n_bad++; $display("FAIL line_first_data got %h want f81f", o_wdata); end
    for (int i = 3; i < 1280; i++) cyc(1'b0, 1'b1, (i % 2 == 1) ? 8'h1F : 8'hF8);
    repeat (4) cyc(1'b0, 1'b0, 8'd0);
    n_cmp++; if (wr_cnt != 640) begin n_bad++; $display("FAIL line_count got %0d want 640", wr_cnt); end
    n_cmp++; if (last_addr !== 19'd639) begin n_bad++; $display("FAIL line_last_addr got %0d want 639", last_addr); end
    n_cmp++; if (bad_seq != 0) begin n_bad++; $display("FAIL line_addr_seq got %0d bad want 0", bad_seq); end
    n_cmp++; if (bad_data != 0) begin n_bad++; $display("FAIL line_data got %0d bad want 0", bad_data); end
    frame_end();
    exp_fc = 1;
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL line_done got %0d want 1", done_cnt); end
    n_cmp++; if (o_frame_count !== 8'(exp_fc)) begin n_bad++; $display("FAIL line_fc got %0d want %0d", o_frame_count, exp_fc); end
  endtask

  task automatic test_frame();
    clear_mon(1'b1, 16'h1234);
    frame_start();
    repeat (4) send_line(1280, 8'h12, 8'h34);
    frame_end();
    exp_fc = 2;
    n_cmp++; if (wr_cnt != 2560) begin n_bad++; $display("FAIL frame_count got %0d want 2560", wr_cnt); end
    n_cmp++; if (first_addr !== 19'd0) begin n_bad++; $display("FAIL frame_first got %0d want 0", first_addr); end
    n_cmp++; if (last_addr !== 19'd2559) begin n_bad++; $display("FAIL frame_last got %0d want 2559", last_addr); end
    n_cmp++; if (bad_data != 0) begin n_bad++; $display("FAIL frame_data got %0d bad want 0", bad_data); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL frame_done got %0d want 1", done_cnt); end
    n_cmp++; if (o_frame_count !== 8'(exp_fc)) begin n_bad++; $display("FAIL frame_fc got %0d want %0d", o_frame_count, exp_fc); end
    n_cmp++; if (o_wdata !== 16'h1234) begin n_bad++; $display("FAIL frame_hold_data got %h want 1234", o_wdata); end
    n_cmp++; if (o_waddr !== 19'd2559) begin n_bad++; $display("FAIL frame_hold_addr got %0d want 2559", o_waddr); end
  endtask

  task automatic test_wrap();
    clear_mon(1'b1, 16'hABCD);
    frame_start();
    repeat (5) send_line(1280, 8'hAB, 8'hCD);
    frame_end();
    exp_fc = 3;
    n_cmp++; if (wr_cnt != 3200) begin n_bad++; $display("FAIL wrap_count got %0d want 3200", wr_cnt); end
    n_cmp++; if (last_addr !== 19'd639) begin n_bad++; $display("FAIL wrap_last got %0d want 639", last_addr); end
    n_cmp++; if (bad_seq != 0) begin n_bad++; $display("FAIL wrap_seq got %0d bad want 0", bad_seq); end
    n_cmp++; if (o_frame_count !== 8'(exp_fc)) begin n_bad++; $display("FAIL wrap_fc got %0d want %0d", o_frame_count, exp_fc); end
  endtask

  task automatic test_odd_line();
    clear_mon(1'b0, 16'h0000);
    frame_start();
`ifdef CAPTURE_LINE_CHECK_EN
    n_cmp++; if (o_line_err !== 1'b0) begin n_bad++; $display("FAIL odd_err_pre got %0d want 0", o_line_err); end
`endif
    send_line(1281, 8'hF8, 8'h1F);
    n_cmp++; if (wr_cnt != 640) begin n_bad++; $display("FAIL odd_count got %0d want 640", wr_cnt); end
    send_line(4, 8'h55, 8'hAA);
    n_cmp++; if (wr_cnt != 642) begin n_bad++; $display("FAIL odd_next_count got %0d want 642", wr_cnt); end
    n_cmp++; if (last_data !== 16'h55AA) begin n_bad++; $display("FAIL odd_next_phase got %h want 55aa", last_data); end
`ifdef CAPTURE_LINE_CHECK_EN
    n_cmp++; if (o_line_err !== 1'b1) begin n_bad++; $display("FAIL odd_err got %0d want 1", o_line_err); end
`endif
    frame_end();
    exp_fc = 4;
  endtask

  task automatic test_pixel_drop();
    clear_mon(1'b0, 16'h0000);
    frame_start();
    send_line(4, 8'h21, 8'h43);
    cyc(1'b0, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    repeat (4) cyc(1'b1, 1'b0, 8'd0);
    exp_fc = 5;
    n_cmp++; if (wr_cnt != 2) begin n_bad++; $display("FAIL drop_count got %0d want 2", wr_cnt); end
    n_cmp++; if (last_data !== 16'h2143) begin n_bad++; $display("FAIL drop_data got %h want 2143", last_data); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL drop_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_enable_drop();
    clear_mon(1'b0, 16'h0000);
    frame_start();
    send_line(8, 8'h01, 8'h02);
    i_enable = 1'b0;
    send_line(8, 8'h03, 8'h04);
    frame_end();
    exp_fc = 6;
    n_cmp++; if (wr_cnt != 8) begin n_bad++; $display("FAIL en_count got %0d want 8", wr_cnt); end
    n_cmp++; if (last_data !== 16'h0304) begin n_bad++; $display("FAIL en_data got %h want 0304", last_data); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL en_done got %0d want 1", done_cnt); end
    clear_mon(1'b0, 16'h0000);
    frame_start();
    send_line(8, 8'h05, 8'h06);
    frame_end();
    n_cmp++; if (wr_cnt != 0) begin n_bad++; $display("FAIL idle_count got %0d want 0", wr_cnt); end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL idle_done got %0d want 0", done_cnt); end
    n_cmp++; if (o_frame_count !== 8'(exp_fc)) begin n_bad++; $display("FAIL idle_fc got %0d want %0d", o_frame_count, exp_fc); end
    i_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    frame_start();
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h77);
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++; if (o_wr !== 1'b0) begin n_bad++; $display("FAIL rmid_wr got %0d want 0", o_wr); end
    n_cmp++; if (o_waddr !== 19'd0) begin n_bad++; $display("FAIL rmid_waddr got %0d want 0", o_waddr); end
    n_cmp++; if (o_wdata !== 16'd0) begin n_bad++; $display("FAIL rmid_wdata got %h want 0", o_wdata); end
    n_cmp++; if (o_frame_count !== 8'd0) begin n_bad++; $display("FAIL rmid_fc got %0d want 0", o_frame_count); end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    clear_mon(1'b0, 16'h0000);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'h99);
    repeat (4) cyc(1'b0, 1'b0, 8'd0);
    n_cmp++; if (wr_cnt != 0) begin n_bad++; $display("FAIL rmid_nowrite got %0d want 0", wr_cnt); end
    frame_start();
    send_line(4, 8'h0F, 8'hF0);
    n_cmp++; if (wr_cnt != 2) begin n_bad++; $display("FAIL rmid_resume got %0d want 2", wr_cnt); end
    n_cmp++; if (first_addr !== 19'd0) begin n_bad++; $display("FAIL rmid_first got %0d want 0", first_addr); end
    n_cmp++; if (last_data !== 16'h0FF0) begin n_bad++; $display("FAIL rmid_data got %h want 0ff0", last_data); end
  endtask

  initial begin
    clear_mon(1'b0, 16'h0000);
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_odd_line();
    test_pixel_drop();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
